// File: rtl/elevator.sv
// elevator: single-car plant model holding the current floor and door state.
// Executes door and motion commands from the dispatch controller; travel
// between adjacent floors takes FLOOR_TICKS consecutive motion edges.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset (floor 0, door closed)
//   door_open door command: 1 = open / hold open, 0 = close
//   updown    motion command: 01 = up, 10 = down, 00/11 = stop
//   door      registered door state, 1 = open
//   floor     registered current floor
module elevator #(
    parameter int unsigned NUM_FLOORS  = 8,
    parameter int unsigned FLOOR_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       door_open,
    input  logic [1:0] updown,
    output logic       door,
    output logic [2:0] floor
);

    localparam int unsigned TICK_W   = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
    localparam logic [2:0]  TOP      = 3'(NUM_FLOORS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FLOOR_TICKS - 1);
    localparam logic [1:0]  DIR_UP   = 2'b01;
    localparam logic [1:0]  DIR_DOWN = 2'b10;

    logic [2:0]        floor_q;
    logic              door_q;
    logic [TICK_W-1:0] tick;
    logic [1:0]        dir_q;

    logic up_ok;
    logic down_ok;

    // A move is only possible when it stays inside the shaft.
    assign up_ok   = (updown == DIR_UP)   && (floor_q < TOP);
    assign down_ok = (updown == DIR_DOWN) && (floor_q != 3'd0);

    // Door handling has priority; motion only happens with the door fully closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            floor_q <= 3'd0;
            door_q  <= 1'b0;
            tick    <= '0;
            dir_q   <= 2'b00;
        end else if (door_open) begin
            door_q <= 1'b1;
            tick   <= '0;
            dir_q  <= 2'b00;
        end else if (door_q) begin
            // Closing edge: the door shuts and the car stays put.
            door_q <= 1'b0;
            tick   <= '0;
            dir_q  <= 2'b00;
        end else begin
            dir_q <= updown;
            if (up_ok || down_ok) begin
                // A fresh direction counts this edge as the first travel tick.
                if ((dir_q != updown) && (FLOOR_TICKS > 1)) begin
                    tick <= TICK_W'(1);
                end else if ((dir_q != updown) || (tick == TICK_LAST)) begin
                    floor_q <= up_ok ? floor_q + 3'd1 : floor_q - 3'd1;
                    tick    <= '0;
                end else begin
                    tick <= tick + TICK_W'(1);
                end
            end else begin
                tick <= '0;
            end
        end
    end

    assign floor = floor_q;
    assign door  = door_q;

endmodule

// File: tb/tb_elevator.sv
module tb_elevator;

    localparam int unsigned NF = 8;
    localparam int unsigned FT = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       door_open;
    logic [1:0] updown;
    logic       door;
    logic [2:0] floor;

    always #5 clk = ~clk;

    elevator #(.NUM_FLOORS(NF), .FLOOR_TICKS(FT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .door_open (door_open),
        .updown    (updown),
        .door      (door),
        .floor     (floor)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a floor is reached after FT consecutive legal edges
    // in one direction; anything else restarts the run.
    int         m_floor;
    int         m_run;
    bit         m_door;
    logic [1:0] m_last;

    typedef struct {
        bit         d;
        logic [1:0] ud;
        int         n;
        int         ef;
        bit         ed;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_floor = 0;
        m_run   = 0;
        m_door  = 0;
        m_last  = 2'b00;
    endtask

    task automatic model_step(input bit d, input logic [1:0] ud);
        bit legal;
        legal = (ud == 2'b01 && m_floor < NF - 1) || (ud == 2'b10 && m_floor > 0);
        if (d) begin
            m_door = 1; m_run = 0; m_last = 2'b00;
        end else if (m_door) begin
            m_door = 0; m_run = 0; m_last = 2'b00;
        end else begin
            if (!legal) begin
                m_run = 0;
            end else begin
                if (ud != m_last) m_run = 0;
                m_run++;
                if (m_run == FT) begin
                    m_floor = m_floor + ((ud == 2'b01) ? 1 : -1);
                    m_run   = 0;
                end
            end
            m_last = ud;
        end
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic cyc(input bit d, input logic [1:0] ud);
        logic [2:0] pf;
        logic       pd;
        door_open = d;
        updown    = ud;
        pf = floor;
        pd = door;
        @(posedge clk);
        model_step(d, ud);
        @(negedge clk);
        chk("floor_vs_model", int'(floor), m_floor);
        chk("door_vs_model", int'(door), int'(m_door));
        chk("floor_door_same_edge", int'((floor != pf) && (door != pd)), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_floor", int'(floor), 0);
        chk("async_reset_door", int'(door), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        door_open = 1'b0;
        updown    = 2'b00;
        model_reset();

        // Hand-derived vector table: {door_open, updown, cycles, floor, door}
        tbl.push_back('{0, 2'b01,  9, 0, 0});  // no move before edge 10
        tbl.push_back('{0, 2'b01,  1, 1, 0});  // floor 1 at edge 10
        tbl.push_back('{0, 2'b01, 10, 2, 0});  // floor 2 at edge 20
        tbl.push_back('{1, 2'b01,  1, 2, 1});  // door overrides up
        tbl.push_back('{0, 2'b00,  1, 2, 0});  // closes one edge later
        tbl.push_back('{0, 2'b01,  5, 2, 0});  // partial up run
        tbl.push_back('{0, 2'b10,  9, 2, 0});  // reversal restarts timer
        tbl.push_back('{0, 2'b10,  1, 1, 0});  // down arrives FT after reversal
        tbl.push_back('{0, 2'b11,  3, 1, 0});  // illegal code holds
        tbl.push_back('{0, 2'b10, 10, 0, 0});
        tbl.push_back('{0, 2'b10, 30, 0, 0});  // no wrap below 0
        tbl.push_back('{0, 2'b01, 70, 7, 0});  // climb to top
        tbl.push_back('{0, 2'b01, 30, 7, 0});  // no wrap above top
        tbl.push_back('{0, 2'b10,  6, 7, 0});  // mid-travel, timer partly run
        tbl.push_back('{1, 2'b10,  1, 7, 1});  // door mid-travel, floor frozen
        tbl.push_back('{0, 2'b10,  1, 7, 0});  // door closing edge
        tbl.push_back('{0, 2'b10,  9, 7, 0});  // full FT needed again
        tbl.push_back('{0, 2'b10,  1, 6, 0});

        #12;
        chk("reset_floor", int'(floor), 0);
        chk("reset_door", int'(door), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            repeat (tbl[i].n) cyc(tbl[i].d, tbl[i].ud);
            chk($sformatf("vec%0d_floor", i), int'(floor), tbl[i].ef);
            chk($sformatf("vec%0d_door", i), int'(door), int'(tbl[i].ed));
        end

        // Reset mid-travel at floor 3
        do_reset();
        repeat (30) cyc(0, 2'b01);
        chk("pre_reset_floor3", int'(floor), 3);
        repeat (4) cyc(0, 2'b01);
        do_reset();
        repeat (3) cyc(0, 2'b00);
        chk("post_reset_hold", int'(floor), 0);

        // Closed-loop stop: 2 -> 5 then a 3-cycle door pulse
        repeat (20) cyc(0, 2'b01);
        chk("at_floor2", int'(floor), 2);
        begin
            int k = 0;
            int rises = 0;
            logic pd;
            while (floor != 3'd5 && k < 100) begin
                cyc(0, 2'b01);
                k++;
            end
            chk("reach_floor5", int'(floor), 5);
            for (int j = 0; j < 6; j++) begin
                pd = door;
                cyc(j < 3, (j < 3) ? 2'b01 : 2'b00);
                if (door && !pd && floor == 3'd5) rises++;
            end
            chk("door_rises_at5", rises, 1);
            chk("stopped_at5", int'(floor), 5);
        end

        // Randomized runs against the model
        do_reset();
        begin
            int cycles = 0;
            while (cycles < 4000) begin
                logic [1:0] ud;
                int         len;
                ud  = 2'($urandom_range(0, 3));
                len = int'($urandom_range(1, 25));
                for (int j = 0; j < len; j++) begin
                    cyc($urandom_range(0, 9) == 0, ud);
                end
                cycles += len;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator.md
# elevator

Single-car elevator plant model: it holds the car's current floor and door state and carries out the move and door commands issued by the target/dispatch controller. It is a leaf block driven by `target_controller`. Its `door` rising edge marks a stop at a floor, and its `floor` output closes the control loop.

## Interface
Parameters:
- `NUM_FLOORS`, default 8: number of floors, indexed 0..NUM_FLOORS-1. Must be at most 8 because `floor` is 3 bits wide.
- `FLOOR_TICKS`, default 10: clock cycles needed to travel one floor. Must be at least 1.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `door_open`  input  1  door command: 1 = open or hold open, 0 = close.
- `updown`  input  2  motion command: 2'b01 = up, 2'b10 = down, 2'b00 = stop, 2'b11 = stop (illegal code, treated as stop).
- `door`  output  1  registered door state: 1 = open.
- `floor`  output  3  registered current floor.

## Operation
- Internal state:
  - `floor_q`, 3 bits
  - `door_q`, 1 bit
  - travel timer `tick`, sized to hold FLOOR_TICKS-1
  - `dir_q`, 2 bits: last accepted direction
- Outputs: `floor = floor_q`, `door = door_q`.
- Reset (rst_n = 0, asynchronous): `floor_q = 0`, `door_q = 0`, `tick = 0`, `dir_q = 2'b00`.
- Each clock edge with rst_n = 1, evaluate in priority order:
  1. **Door open.** If `door_open` = 1: `door_q <= 1`, `tick <= 0`, floor holds. The door command overrides any motion command; the car never moves while the door is commanded open.
  2. **Door closing.** Otherwise, if `door_q` = 1: `door_q <= 0`, `tick <= 0`, floor holds. Closing the door takes one cycle, and no motion occurs on that edge.
  3. **Motion.** Otherwise (door closed, `door_open` = 0), apply `updown`:
     - Up (01) and `floor_q` < NUM_FLOORS-1: if `dir_q` ≠ 01, the partial timer is discarded (`tick <= 1`, or the floor advances immediately if FLOOR_TICKS = 1). Otherwise, when `tick` = FLOOR_TICKS-1: `floor_q <= floor_q + 1` and `tick <= 0`; else `tick <= tick + 1`.
     - Down (10) and `floor_q` > 0: symmetric, decrementing.
     - Up at the top floor, down at floor 0, stop (00) or 11: floor holds and `tick <= 0`. Floor never wraps.
     - `dir_q <= updown` on every motion-phase edge. `dir_q <= 00` on any door-phase edge.
- Floor changes by at most 1 per edge.
- `floor` and `door` never change on the same edge.

## Timing
- `door` follows `door_open` with 1-cycle latency:
  - rising edge of `door` one clock after `door_open` is sampled high;
  - falling edge one clock after `door_open` is sampled low.
- Travel from rest with the door closed: `updown` = up is sampled on edge 1, and `floor` increments on edge FLOOR_TICKS. Each further floor takes another FLOOR_TICKS edges while `updown` is held.
- After the door closes, the first motion-phase edge is the one after `door` falls.
- Stop, a direction change, or asserting `door_open` mid-travel discards the partial timer. Resumed travel needs a full FLOOR_TICKS.
- `rst_n` low mid-travel or with the door open forces floor 0, door closed, timer 0 immediately (asynchronously).
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-travel at floor 3 -> `floor` = 0 and `door` = 0 immediately; they stay there until commands resume.
- **Single-floor up:** FLOOR_TICKS = 10, `updown` = 01 from floor 0 -> `floor` = 1 at edge 10 and 2 at edge 20; unchanged at edges 1-9.
- **Limits:** at floor 7 hold up for 30 cycles -> `floor` stays 7. At floor 0 hold down for 30 cycles -> stays 0, no wrap.
- **Door override:** moving up, `tick` = 5, assert `door_open` -> `door` = 1 next edge, `floor` frozen. Deassert -> `door` = 0 one edge later. Moving then resumes and the next floor arrives FLOOR_TICKS edges after the first motion edge.
- **Direction reversal and illegal code:** up for 5 cycles, then down -> no floor change for the first 5 cycles; floor decrements FLOOR_TICKS edges after the reversal. `updown` = 11 -> floor holds, timer cleared.
- **Closed-loop stop:** drive the car from 2 to 5, then pulse `door_open` for 3 cycles on arrival -> exactly one `door` rising edge while `floor` = 5; `floor` never changes while `door` = 1.
